frame_serializer: RTL

//  Multi-channel, parametrised successor to the single-channel parallel_to_serial stimulus driver.

---
 rtl/frame_serializer_pkg.sv | 23 ++
 rtl/frame_serializer_sync_fifo.sv | 60 ++++++
 rtl/frame_serializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_serializer_pkg.sv
// Shared definitions for frame_serializer: FSM encodings, default geometry and a width helper.
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 16
`endif

package frame_serializer_pkg;

   localparam int unsigned FSER_DEF_WIDTH    = `INPUT_WIDTH;
   localparam int unsigned FSER_DEF_CHANNELS = 2;

   typedef enum logic [1:0] {
      FSER_IDLE  = 2'd0,
      FSER_LOAD  = 2'd1,
      FSER_SHIFT = 2'd2,
      FSER_GAP   = 2'd3
   } fser_state_e;

   // Bit-counter width; a 1-bit word still needs a 1-bit counter.
   function automatic int unsigned fser_cnt_w(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/frame_serializer_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered full/empty flags and occupancy level.
module frame_serializer_sync_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en_i,
   input  logic [DW-1:0]          wr_data_i,
   input  logic                   rd_en_i,
   output logic [DW-1:0]          rd_data_c,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] level_d;
   logic          full_d, empty_d;
   logic          wr_fire, rd_fire;

   assign wr_fire   = wr_en_i && !full_o;
   assign rd_fire   = rd_en_i && !empty_o;
   assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

   // Flags are derived from the next pointers so they can be registered.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_fire);
      rd_ptr_d = rd_ptr_q + PW'(rd_fire);
      level_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (level_d == PW'(DEPTH));
      empty_d  = (level_d == '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_o  <= '0;
         full_o   <= 1'b0;
         empty_o  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_o  <= level_d;
         full_o   <= full_d;
         empty_o  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/frame_serializer.sv
// Multi-lane MSB-first frame serializer with input FIFO, frame strobe and programmable gap.
// Define FSER_PARITY_EN to append an even-parity bit per lane after each word's LSB.
module frame_serializer
   import frame_serializer_pkg::*;
#(
   parameter int unsigned WIDTH    = FSER_DEF_WIDTH,
   parameter int unsigned CHANNELS = FSER_DEF_CHANNELS,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned GAP_W    = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [GAP_W-1:0]            cfg_gap,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CHANNELS*WIDTH-1:0]   in_data,
   output logic                        frame,
   output logic [CHANNELS-1:0]         serial_out,
   output logic                        busy,
   output logic                        underrun,
   output logic [$clog2(DEPTH):0]      fifo_level
);

   localparam int unsigned CNT_W = fser_cnt_w(WIDTH);
   localparam int unsigned DW    = CHANNELS * WIDTH;

   fser_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [GAP_W-1:0]    gcnt_q, gcnt_d;
   logic                pop_c, load_c, shift_c, start_c, last_bit_c;
   logic                fifo_full, fifo_empty;
   logic [DW-1:0]       head_c;
   logic [CHANNELS-1:0] msb_c;
   logic [CHANNELS-1:0] serial_d;
   logic                frame_d, busy_d, underrun_d;
`ifdef FSER_PARITY_EN
   logic                par_ph_q, par_ph_d;
   logic [CHANNELS-1:0] par_q, par_d, head_par_c;
`endif

   frame_serializer_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (in_valid),
      .wr_data_i (in_data),
      .rd_en_i   (pop_c),
      .rd_data_c (head_c),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   assign in_ready = ~fifo_full;

`ifdef FSER_PARITY_EN
   assign last_bit_c = par_ph_q;
`else
   assign last_bit_c = (cnt_q == '0);
`endif

   // Next-state logic; nothing on the shift side moves while enable is low.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      gcnt_d     = gcnt_q;
      underrun_d = 1'b0;
      pop_c      = 1'b0;
      load_c     = 1'b0;
      shift_c    = 1'b0;
      start_c    = 1'b0;
`ifdef FSER_PARITY_EN
      par_ph_d   = par_ph_q;
      par_d      = par_q;
`endif
      if (enable) begin
`ifdef FSER_PARITY_EN
         par_ph_d = 1'b0;
`endif
         case (state_q)
            FSER_IDLE: begin
               if (!fifo_empty) state_d = FSER_LOAD;
            end
            FSER_LOAD: begin
               start_c = 1'b1;
            end
            FSER_SHIFT: begin
               if (last_bit_c) begin
                  if (gap_q != '0) begin
                     state_d = FSER_GAP;
                     gcnt_d  = gap_q - GAP_W'(1);
                  end else if (!fifo_empty) begin
                     start_c = 1'b1;
                  end else begin
                     underrun_d = 1'b1;
                     state_d    = FSER_IDLE;
                  end
               end
`ifdef FSER_PARITY_EN
               else if (cnt_q == '0) begin
                  par_ph_d = 1'b1;
               end
`endif
               else begin
                  shift_c = 1'b1;
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            FSER_GAP: begin
               if (gcnt_q == '0) begin
                  if (!fifo_empty) begin
                     state_d = FSER_LOAD;
                  end else begin
                     underrun_d = 1'b1;
                     state_d    = FSER_IDLE;
                  end
               end else begin
                  gcnt_d = gcnt_q - GAP_W'(1);
               end
            end
            default: state_d = FSER_IDLE;
         endcase

         // Frame start: pop the head entry and sample the gap for this frame.
         if (start_c) begin
            pop_c   = 1'b1;
            load_c  = 1'b1;
            gap_d   = cfg_gap;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = FSER_SHIFT;
`ifdef FSER_PARITY_EN
            par_d   = head_par_c;
`endif
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic [WIDTH-1:0] sreg_q, sreg_d, word_c;

      assign word_c = head_c[c*WIDTH +: WIDTH];

      always_comb begin
         sreg_d = sreg_q;
         if (load_c)       sreg_d = word_c;
         else if (shift_c) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) sreg_q <= '0;
         else        sreg_q <= sreg_d;
      end

      assign msb_c[c] = sreg_d[WIDTH-1];
`ifdef FSER_PARITY_EN
      assign head_par_c[c] = ^word_c;
`endif
   end

   // Output values are decoded from next state so the registered outputs line up with it.
   always_comb begin
      serial_d = '0;
      if (state_d == FSER_SHIFT) begin
`ifdef FSER_PARITY_EN
         serial_d = par_ph_d ? par_d : msb_c;
`else
         serial_d = msb_c;
`endif
      end
      frame_d = (state_d == FSER_SHIFT) && (cnt_d == CNT_W'(WIDTH - 1));
      busy_d  = (state_d != FSER_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FSER_IDLE;
         cnt_q      <= '0;
         gap_q      <= '0;
         gcnt_q     <= '0;
         frame      <= 1'b0;
         serial_out <= '0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         gcnt_q     <= gcnt_d;
         frame      <= frame_d;
         serial_out <= serial_d;
         busy       <= busy_d;
         underrun   <= underrun_d;
      end
   end

`ifdef FSER_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_ph_q <= 1'b0;
         par_q    <= '0;
      end else begin
         par_ph_q <= par_ph_d;
         par_q    <= par_d;
      end
   end
`endif

endmodule
